apb_sram_slave: RTL and testbench
=================================

// Module: apb_sram_slave
// PURPOSE
//  APB responder fronting a single-port word-addressed SRAM; the DUT end of the apb_inf bus.
//  Decodes setup/access phases, inserts optional wait states, flags out-of-range accesses on pslverr.
//  Detects requester protocol violations and reports them on a one-cycle pulse.
// PARAMETERS
//  ADDR_WIDTH   `ADDR_WIDTH   paddr width; paddr is a word index, not a byte address
//  DATA_WIDTH   `DATA_WIDTH   pwdata/prdata width and SRAM word width
//  MEM_DEPTH    256           SRAM words; valid paddr range 0..MEM_DEPTH-1
//  WAIT_CYCLES  2             access-phase wait states, used only with APB_SRAM_WAIT_EN (0 allowed)
// PORTS
//  clk       in   1           single clock, all logic on posedge
//  rst_n     in   1           asynchronous active-low reset
//  psel      in   1           APB select
//  penable   in   1           APB enable (access phase)
//  pwrite    in   1           1=write, 0=read
//  paddr     in   ADDR_WIDTH  word address
//  pwdata    in   DATA_WIDTH  write data
//  prdata    out  DATA_WIDTH  read data
//  pready    out  1           transfer complete
//  pslverr   out  1           transfer error
//  apb_viol  out  1           1-cycle pulse on requester protocol violation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, prdata=0, wait_cnt=0, apb_viol=0; pready/pslverr=0 combinationally.
//  SRAM contents are not reset.
//  FSM: IDLE -> SETUP when psel && !penable; SETUP -> ACCESS unconditionally next cycle;
//   ACCESS -> IDLE on completion (psel && penable && pready).
//  Setup edge (IDLE, psel && !penable): latch addr_q=paddr, wr_q=pwrite, err_q=(paddr>=MEM_DEPTH).
//   Read with !err: prdata <= mem[paddr]. Read with err: prdata <= 0.
//  Write prdata: unchanged.
//  pready = (state==ACCESS) && psel && penable && (wait_cnt==0); combinational.
//  pslverr = pready && err_q; never high without pready.
//  Write commit: at the completing edge, mem[addr_q] <= pwdata iff wr_q && !err_q; pwdata sampled then.
//  Read latency: prdata valid from the first ACCESS cycle, held until the next read setup.
//  Latched addr_q/wr_q are used; paddr/pwrite changes during ACCESS are ignored.
//  Violations (apb_viol=1 next cycle, FSM -> IDLE, no SRAM write):
//   SETUP with !psel or penable already high;
//   ACCESS with !psel or !penable before completion;
//   penable high in IDLE (stay IDLE).
//  Back-to-back: completion -> IDLE; a setup in the very next cycle is accepted. No idle cycle required.
//  Address wrap: none; paddr >= MEM_DEPTH is always an error, never aliased.
//  Reset mid-transfer: abort immediately, no SRAM write, pready drops same cycle.
// CONFIGURATION
//  APB_SRAM_WAIT_EN defined:
//   - wait_cnt loads WAIT_CYCLES at the setup edge and decrements each ACCESS cycle while nonzero.
//   - pready rises on ACCESS cycle WAIT_CYCLES+1.
//   - Waits apply to error transfers too.
//  APB_SRAM_WAIT_EN undefined:
//   - wait_cnt logic is removed; treated as 0.
//   - pready is high in the first ACCESS cycle (zero-wait).
//   - WAIT_CYCLES is ignored.
// TESTING
//  1 rst_n=0 mid-sim -> pready=0, pslverr=0, prdata=0, apb_viol=0 asynchronously.
//  2 write paddr=0x10 pwdata=0xDEADBEEF, then read 0x10 -> prdata=0xDEADBEEF.
//    No macro: pready in first ACCESS cycle, pslverr=0.
//  3 write paddr=300 (MEM_DEPTH=256) data 0x1234 -> pready=pslverr=1.
//    Read 300 -> pslverr=1, prdata=0; read 300-256=44 -> unchanged.
//  4 APB_SRAM_WAIT_EN, WAIT_CYCLES=2: write 0x05=0xA5A5A5A5 -> pready low 2 ACCESS cycles, high on 3rd.
//    Readback matches.
//  5 psel dropped in ACCESS of write 0x20=0x11111111 -> apb_viol pulse 1 cycle, FSM IDLE.
//    Read 0x20 -> old value.
//  6 back-to-back write 0x30 then read 0x30 with no idle cycle -> both complete, read returns written data;
//    rst_n pulse during a wait state -> no write.

Source files
------------

// File: rtl/apb_sram_slave.sv
// apb_sram_slave: APB responder in front of a single-port, word-addressed SRAM.
// A transfer is seen as IDLE (setup request) -> SETUP -> ACCESS; address, direction
// and range error are captured when the request is first seen in IDLE.
// Out-of-range word addresses complete with pslverr and never touch the SRAM.
// Requester protocol violations abort the transfer and pulse apb_viol for one cycle.
// Optional feature macro: APB_SRAM_WAIT_EN adds WAIT_CYCLES wait states to every
// access phase; without it the slave answers in the first ACCESS cycle.
module apb_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  apb_viol
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Only the SRAM index bits are kept; anything beyond the array is captured in err_q.
    logic [IDX_W-1:0]      addr_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic setup_edge;
    logic addr_err;
    logic wait_done;
    logic viol;
    logic commit;

    assign setup_edge = (state == IDLE) && psel && !penable;
    assign addr_err   = ({1'b0, paddr} >= DEPTH_L);

`ifdef APB_SRAM_WAIT_EN
    localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WAIT_W-1:0] wait_cnt;

    // Wait-state counter: armed at the setup edge, counts down through the access phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (setup_edge) begin
            wait_cnt <= WAIT_W'(WAIT_CYCLES);
        end else if ((state == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign wait_done = (wait_cnt == '0);
`else
    // Zero-wait build: the access phase always completes in its first cycle,
    // so WAIT_CYCLES has no effect here.
    logic unused_wait_cycles;
    assign unused_wait_cycles = WAIT_CYCLES[0];
    assign wait_done          = 1'b1;
`endif

    assign pready  = (state == ACCESS) && psel && penable && wait_done;
    assign pslverr = pready && err_q;
    assign commit  = pready && wr_q && !err_q;

    // Next-state decode and violation detection for the requester handshake.
    always_comb begin
        state_next = state;
        viol       = 1'b0;
        case (state)
            IDLE: begin
                if (penable) begin
                    viol = 1'b1;
                end else if (psel) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (!psel || penable) begin
                    viol       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    viol       = 1'b1;
                    state_next = IDLE;
                end else if (pready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the registered one-cycle violation pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            apb_viol <= 1'b0;
        end else begin
            state    <= state_next;
            apb_viol <= viol;
        end
    end

    // Capture the request at the setup edge; reads fetch their word right away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            prdata <= '0;
        end else if (setup_edge) begin
            addr_q <= paddr[IDX_W-1:0];
            wr_q   <= pwrite;
            err_q  <= addr_err;
            if (!pwrite) begin
                prdata <= addr_err ? '0 : mem[paddr[IDX_W-1:0]];
            end
        end
    end

    // SRAM write port: commits only on a successful, completing write.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[addr_q] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// tb_apb_sram_slave: randomized APB traffic against a word-array reference model,
// plus directed cases for errors, protocol violations, back-to-back and mid-transfer reset.
module tb_apb_sram_slave;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WAITS = 2;
`ifdef APB_SRAM_WAIT_EN
    localparam int EXP_WAIT = WAITS;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          apb_viol;

    logic [DW-1:0] modelMem [DEPTH];
    logic [DW-1:0] modelPrdata;
    int            compareCount;
    int            failCount;

    apb_sram_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .apb_viol(apb_viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < n; i++) nextCycle();
    endtask

    // One complete transfer: two setup cycles, then access until pready.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic expErr;
        int   waits;
        bit   done;
        bit   sawViol;
        bit   errNoReady;
        bit   first;
        expErr     = (int'(addr) >= DEPTH);
        waits      = 0;
        done       = 0;
        sawViol    = 0;
        errNoReady = 0;
        first      = 1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        nextCycle();
        @(negedge clk);
        if (apb_viol || pready || pslverr) sawViol = 1;
        nextCycle();
        penable = 1'b1;
        pwrite  = ~wr;
        paddr   = addr ^ 16'h5A5A;
        if (!wr) modelPrdata = expErr ? '0 : modelMem[addr[7:0]];
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (first) checkOutput("prdata_first_access", prdata, modelPrdata);
            first = 0;
            if (apb_viol) sawViol = 1;
            if (pready) begin
                checkOutput("pslverr", pslverr, expErr);
                done = 1;
            end else begin
                if (pslverr) errNoReady = 1;
                waits++;
            end
            nextCycle();
        end
        checkOutput("completed", done, 1);
        checkOutput("wait_states", waits, EXP_WAIT);
        checkOutput("no_viol_in_transfer", sawViol, 0);
        checkOutput("pslverr_without_pready", errNoReady, 0);
        if (wr && !expErr) modelMem[addr[7:0]] = data;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Called with the offending inputs already driven for the current cycle.
    task automatic expectViolPulse(input string tag);
        nextCycle();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_pulse"}, apb_viol, 1);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, "_clear"}, apb_viol, 0);
        nextCycle();
    endtask

    task automatic violAccessDrop(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        nextCycle();
        nextCycle();
        psel    = 1'b0;
        penable = 1'b0;
        expectViolPulse("viol_access_drop");
    endtask

    task automatic violSetupPenable(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        nextCycle();
        penable = 1'b1;
        expectViolPulse("viol_setup_penable");
    endtask

    task automatic violIdlePenable();
        psel    = 1'b0;
        penable = 1'b1;
        expectViolPulse("viol_idle_penable");
    endtask

    task automatic resetMidTransfer(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        nextCycle();
        nextCycle();
        penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pready", pready, 0);
        checkOutput("rst_pslverr", pslverr, 0);
        checkOutput("rst_prdata", prdata, 0);
        checkOutput("rst_apb_viol", apb_viol, 0);
        psel    = 1'b0;
        penable = 1'b0;
        nextCycle();
        rst_n       = 1'b1;
        modelPrdata = '0;
        nextCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic          wr;
        logic [AW-1:0] addr;
        compareCount = 0;
        failCount    = 0;
        modelPrdata  = '0;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        #7;
        checkOutput("reset_pready", pready, 0);
        checkOutput("reset_pslverr", pslverr, 0);
        checkOutput("reset_prdata", prdata, 0);
        checkOutput("reset_apb_viol", apb_viol, 0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, AW'(a), $urandom);

        applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF);
        applyStimulus(1'b0, 16'h0010, '0);
        checkOutput("read_0x10", prdata, 32'hDEADBEEF);
        idleCycles(1);

        applyStimulus(1'b1, 16'd300, 32'h00001234);
        applyStimulus(1'b0, 16'd300, '0);
        checkOutput("read_oob_data", prdata, 0);
        applyStimulus(1'b0, 16'd44, '0);
        idleCycles(2);

        applyStimulus(1'b1, 16'h0005, 32'hA5A5A5A5);
        applyStimulus(1'b0, 16'h0005, '0);
        checkOutput("read_0x05", prdata, 32'hA5A5A5A5);
        idleCycles(1);

        violAccessDrop(16'h0020, 32'h11111111);
        applyStimulus(1'b0, 16'h0020, '0);
        idleCycles(1);

        applyStimulus(1'b1, 16'h0030, 32'h0BADF00D);
        applyStimulus(1'b0, 16'h0030, '0);
        checkOutput("b2b_read_0x30", prdata, 32'h0BADF00D);
        idleCycles(1);

        violSetupPenable(16'h0021, 32'h22222222);
        applyStimulus(1'b0, 16'h0021, '0);
        idleCycles(1);

        violIdlePenable();
        applyStimulus(1'b0, 16'h0022, '0);
        idleCycles(1);

        resetMidTransfer(16'h0040, 32'h44444444);
        applyStimulus(1'b0, 16'h0040, '0);
        idleCycles(1);

        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 9) == 0) addr = AW'($urandom_range(DEPTH, 65535));
            else addr = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus(wr, addr, $urandom);
            idleCycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
